// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_seq_checker
// Purpose  : Passive checker that predicts each counter sample from the last
//            one. It locks on a run of good increments and logs mismatches
//            and wraps.
// Revision : 1.0
// ============================================================================
module count_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             sticky_err,
    output logic [15:0]      err_count,
    output logic [15:0]      wrap_count,
    output logic [WIDTH-1:0] first_err_val
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0]       C_LOCK_CNT = 8'(LOCK_CNT);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [15:0]      C_SAT      = 16'hFFFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev_count;
    logic             r_prev_en;
    logic [7:0]       r_good_run;
    logic [7:0]       w_good_run_nxt;

    logic [WIDTH-1:0] w_exp;
    logic             w_cmp;
    logic             w_match;
    logic             w_err;
    logic             w_inc_ok;
    logic             w_wrap;

    // Prediction is purely from the previous sample; IDLE has no history yet.
    assign w_exp    = r_prev_count + WIDTH'(r_prev_en);
    assign w_cmp    = (r_state != S_IDLE);
    assign w_match  = (count == w_exp);
    assign w_err    = w_cmp && !w_match;
    assign w_inc_ok = w_cmp && w_match && r_prev_en;
    assign w_wrap   = w_inc_ok && (r_prev_count == C_ALL_ONES);

    always_comb begin
        w_state_nxt    = r_state;
        w_good_run_nxt = r_good_run;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_ACQUIRE;
            end
            S_ACQUIRE: begin
                if (w_err) begin
                    w_good_run_nxt = '0;
                end else if (w_inc_ok) begin
                    w_good_run_nxt = r_good_run + 8'd1;
                    if ((r_good_run + 8'd1) == C_LOCK_CNT) begin
                        w_state_nxt = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (w_err) begin
                    w_good_run_nxt = '0;
                    w_state_nxt    = S_ACQUIRE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_good_run_nxt = '0;
            end
        endcase
    end

    // Sample history reloads every cycle, so a mismatch re-synchronises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev_count <= '0;
            r_prev_en    <= 1'b0;
            r_good_run   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_count <= count;
            r_prev_en    <= en;
            r_good_run   <= w_good_run_nxt;
        end
    end

    // Statistics: clear overrides any same-cycle update, but not the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            sticky_err    <= 1'b0;
            err_count     <= '0;
            wrap_count    <= '0;
            first_err_val <= '0;
        end else begin
            locked    <= (w_state_nxt == S_LOCKED);
            err_pulse <= w_err;
            if (clear) begin
                sticky_err    <= 1'b0;
                err_count     <= '0;
                wrap_count    <= '0;
                first_err_val <= '0;
            end else begin
                if (w_err) begin
                    if (err_count != C_SAT) begin
                        err_count <= err_count + 16'd1;
                    end
                    if (!sticky_err) begin
                        sticky_err    <= 1'b1;
                        first_err_val <= count;
                    end
                end
                if (w_wrap && (wrap_count != C_SAT)) begin
                    wrap_count <= wrap_count + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
